// File: rtl/oled_pkg.sv
// Shared constants, FSM state type and window check for the OLED SPI sink.
package oled_pkg;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam int C_X_SIZE_DEF     = 160;
    localparam int C_Y_SIZE_DEF     = 80;
    localparam int C_COLOR_BITS_DEF = 16;

    typedef enum logic [2:0] {
        ST_CMD       = 3'd0,
        ST_CASET_ARG = 3'd1,
        ST_RASET_ARG = 3'd2,
        ST_RAMWR_HI  = 3'd3,
        ST_RAMWR_LO  = 3'd4
    } oled_state_e;

    // A window is accepted only if it is ordered and fits inside the panel.
    function automatic logic window_ok(input logic [15:0] start_v,
                                       input logic [15:0] end_v,
                                       input logic [15:0] size_v);
        return (start_v <= end_v) && (end_v < size_v);
    endfunction

endpackage

// File: rtl/oled_spi_sink_spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronizers, oled_clk rise detect, MSB-first shifter.
module oled_spi_sink_spi_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       oled_csn,
    input  logic       oled_clk,
    input  logic       oled_mosi,
    input  logic       oled_dc,
    input  logic       oled_resn,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       byte_dc,
    output logic       frag_err,
    output logic       resn_sync
);

    logic       csn_s1_q, csn_s2_q, csn_s3_q;
    logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic       dc_s1_q, dc_s2_q;
    logic       resn_s1_q, resn_s2_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_dc_q, byte_dc_d;
    logic       byte_valid_q, byte_valid_d;
    logic       frag_err_q, frag_err_d;
    logic       rise_s;

    // Two-flop synchronizers plus the extra stage used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            csn_s1_q  <= 1'b1;
            csn_s2_q  <= 1'b1;
            csn_s3_q  <= 1'b1;
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            dc_s1_q   <= 1'b0;
            dc_s2_q   <= 1'b0;
            resn_s1_q <= 1'b1;
            resn_s2_q <= 1'b1;
        end else begin
            csn_s1_q  <= oled_csn;
            csn_s2_q  <= csn_s1_q;
            csn_s3_q  <= csn_s2_q;
            sclk_s1_q <= oled_clk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= oled_mosi;
            mosi_s2_q <= mosi_s1_q;
            dc_s1_q   <= oled_dc;
            dc_s2_q   <= dc_s1_q;
            resn_s1_q <= oled_resn;
            resn_s2_q <= resn_s1_q;
        end
    end

    assign rise_s = sclk_s2_q & ~sclk_s3_q & ~csn_s2_q;

    // Bit counting and byte assembly; a deselect mid-byte drops the fragment.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_dc_d    = byte_dc_q;
        byte_valid_d = 1'b0;
        frag_err_d   = 1'b0;
        if (csn_s2_q) begin
            bit_cnt_d  = 3'd0;
            frag_err_d = ~csn_s3_q && (bit_cnt_q != 3'd0);
        end else if (rise_s) begin
            shift_d = {shift_q[5:0], mosi_s2_q};
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_d       = {shift_q, mosi_s2_q};
                byte_dc_d    = dc_s2_q;
                bit_cnt_d    = 3'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_q       <= 8'd0;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            frag_err_q   <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_dc_q    <= byte_dc_d;
            byte_valid_q <= byte_valid_d;
            frag_err_q   <= frag_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = byte_q;
    assign byte_dc    = byte_dc_q;
    assign frag_err   = frag_err_q;
    assign resn_sync  = resn_s2_q;

endmodule

// File: rtl/oled_spi_sink.sv
// ST7735-style display sink: decodes CASET/RASET/RAMWR/SWRESET and emits pixel writes.
module oled_spi_sink
    import oled_pkg::*;
#(
    parameter int C_x_size     = C_X_SIZE_DEF,
    parameter int C_y_size     = C_Y_SIZE_DEF,
    parameter int C_color_bits = C_COLOR_BITS_DEF,
    localparam int C_x_bits    = $clog2(C_x_size),
    localparam int C_y_bits    = $clog2(C_y_size)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    oled_csn,
    input  logic                    oled_clk,
    input  logic                    oled_mosi,
    input  logic                    oled_dc,
    input  logic                    oled_resn,
    output logic                    cmd_valid,
    output logic [7:0]              cmd,
    output logic                    pix_valid,
    output logic [C_x_bits-1:0]     pix_x,
    output logic [C_y_bits-1:0]     pix_y,
    output logic [C_color_bits-1:0] pix_color,
    output logic                    frame_done,
    output logic                    err
);

    localparam logic [15:0]         C_x_lim = 16'(C_x_size);
    localparam logic [15:0]         C_y_lim = 16'(C_y_size);
    localparam logic [C_x_bits-1:0] C_x_max = C_x_bits'(C_x_size - 1);
    localparam logic [C_y_bits-1:0] C_y_max = C_y_bits'(C_y_size - 1);

    logic        byte_valid_s;
    logic [7:0]  rx_byte_s;
    logic        byte_dc_s;
    logic        frag_err_s;
    logic        resn_sync_s;
    logic [15:0] start_s, end_s;
    logic        clear_s;

    oled_state_e state_q, state_d;
    logic [C_x_bits-1:0] xs_q, xs_d, xe_q, xe_d, cur_x_q, cur_x_d;
    logic [C_y_bits-1:0] ys_q, ys_d, ye_q, ye_d, cur_y_q, cur_y_d;
    logic [1:0]  arg_cnt_q, arg_cnt_d;
    logic [23:0] arg_q, arg_d;
    logic [7:0]  hi_q, hi_d;

    logic                    cmd_valid_q, cmd_valid_d;
    logic [7:0]              cmd_q, cmd_d;
    logic                    pix_valid_q, pix_valid_d;
    logic [C_x_bits-1:0]     pix_x_q, pix_x_d;
    logic [C_y_bits-1:0]     pix_y_q, pix_y_d;
    logic [C_color_bits-1:0] pix_color_q, pix_color_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_q, err_d;

    oled_spi_sink_spi_byte_rx u_rx (
        .clk        (clk),
        .rst        (rst),
        .oled_csn   (oled_csn),
        .oled_clk   (oled_clk),
        .oled_mosi  (oled_mosi),
        .oled_dc    (oled_dc),
        .oled_resn  (oled_resn),
        .byte_valid (byte_valid_s),
        .rx_byte    (rx_byte_s),
        .byte_dc    (byte_dc_s),
        .frag_err   (frag_err_s),
        .resn_sync  (resn_sync_s)
    );

    assign start_s = arg_q[23:8];
    assign end_s   = {arg_q[7:0], rx_byte_s};
    assign clear_s = rst | ~resn_sync_s;

    // Command decode, argument collection, window commit and cursor advance.
    always_comb begin
        state_d      = state_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        arg_cnt_d    = arg_cnt_q;
        arg_d        = arg_q;
        hi_d         = hi_q;
        cmd_valid_d  = 1'b0;
        cmd_d        = cmd_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_color_d  = pix_color_q;
        frame_done_d = 1'b0;
        err_d        = frag_err_s;
        if (byte_valid_s && !byte_dc_s) begin
            if (rx_byte_s != CMD_NOP) begin
                cmd_valid_d = 1'b1;
                cmd_d       = rx_byte_s;
                arg_cnt_d   = 2'd0;
                case (rx_byte_s)
                    CMD_CASET: state_d = ST_CASET_ARG;
                    CMD_RASET: state_d = ST_RASET_ARG;
                    CMD_RAMWR: begin
                        state_d = ST_RAMWR_HI;
                        cur_x_d = xs_q;
                        cur_y_d = ys_q;
                    end
                    CMD_SWRESET: begin
                        state_d = ST_CMD;
                        xs_d    = '0;
                        xe_d    = C_x_max;
                        ys_d    = '0;
                        ye_d    = C_y_max;
                    end
                    default: state_d = ST_CMD;
                endcase
            end else begin
                state_d = state_q;
            end
        end else if (byte_valid_s) begin
            case (state_q)
                ST_CASET_ARG, ST_RASET_ARG: begin
                    if (arg_cnt_q == 2'd3) begin
                        state_d   = ST_CMD;
                        arg_cnt_d = 2'd0;
                        if (state_q == ST_CASET_ARG && window_ok(start_s, end_s, C_x_lim)) begin
                            xs_d = start_s[C_x_bits-1:0];
                            xe_d = end_s[C_x_bits-1:0];
                        end else if (state_q == ST_RASET_ARG && window_ok(start_s, end_s, C_y_lim)) begin
                            ys_d = start_s[C_y_bits-1:0];
                            ye_d = end_s[C_y_bits-1:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        arg_d     = {arg_q[15:0], rx_byte_s};
                        arg_cnt_d = arg_cnt_q + 2'd1;
                    end
                end
                ST_RAMWR_HI: begin
                    hi_d    = rx_byte_s;
                    state_d = ST_RAMWR_LO;
                end
                ST_RAMWR_LO: begin
                    state_d      = ST_RAMWR_HI;
                    pix_valid_d  = 1'b1;
                    pix_x_d      = cur_x_q;
                    pix_y_d      = cur_y_q;
                    pix_color_d  = {hi_q, rx_byte_s};
                    frame_done_d = (cur_x_q == xe_q) && (cur_y_q == ye_q);
                    if (cur_x_q < xe_q) begin
                        cur_x_d = cur_x_q + 1'b1;
                    end else begin
                        cur_x_d = xs_q;
                        if (cur_y_q < ye_q) begin
                            cur_y_d = cur_y_q + 1'b1;
                        end else begin
                            cur_y_d = ys_q;
                        end
                    end
                end
                default: state_d = ST_CMD;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Decoder and output registers; display reset clears them like rst.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            state_q      <= ST_CMD;
            xs_q         <= '0;
            xe_q         <= C_x_max;
            ys_q         <= '0;
            ye_q         <= C_y_max;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            arg_cnt_q    <= 2'd0;
            arg_q        <= 24'd0;
            hi_q         <= 8'd0;
            cmd_valid_q  <= 1'b0;
            cmd_q        <= 8'd0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_color_q  <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            arg_cnt_q    <= arg_cnt_d;
            arg_q        <= arg_d;
            hi_q         <= hi_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_color_q  <= pix_color_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd        = cmd_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_color  = pix_color_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: SPI bytes at clk/8, outputs sampled on clk falling edges.
module tb_oled_spi_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic       oled_csn, oled_clk, oled_mosi, oled_dc, oled_resn;
    logic       cmd_valid, pix_valid, frame_done, err;
    logic [7:0] cmd;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [15:0] pix_color;

    int n_checks = 0;
    int n_fail   = 0;

    // Snapshot taken 4 clk after the last rising oled_clk of a byte.
    logic        c_cmd_valid, c_pix_valid, c_frame_done, c_err, c_early;
    logic [7:0]  c_cmd;
    logic [7:0]  c_x;
    logic [6:0]  c_y;
    logic [15:0] c_color;

    oled_spi_sink dut (
        .clk        (clk),
        .rst        (rst),
        .oled_csn   (oled_csn),
        .oled_clk   (oled_clk),
        .oled_mosi  (oled_mosi),
        .oled_dc    (oled_dc),
        .oled_resn  (oled_resn),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_color  (pix_color),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic dc, input logic [7:0] data);
        c_early = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            oled_clk  = 1'b0;
            oled_mosi = data[i];
            oled_dc   = dc;
            repeat (3) @(negedge clk);
            oled_clk = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (i == 0 && k < 4 && (cmd_valid || pix_valid || err))
                    c_early = 1'b1;
                if (i == 0 && k == 4) begin
                    c_cmd_valid  = cmd_valid;
                    c_cmd        = cmd;
                    c_pix_valid  = pix_valid;
                    c_x          = pix_x;
                    c_y          = pix_y;
                    c_color      = pix_color;
                    c_frame_done = frame_done;
                    c_err        = err;
                end
            end
        end
        @(negedge clk);
        oled_clk = 1'b0;
    endtask

    task automatic send_pixel(input logic [15:0] color);
        send_byte(1'b1, color[15:8]);
        send_byte(1'b1, color[7:0]);
    endtask

    task automatic expect_pixel(input string name, input logic [7:0] ex, input logic [6:0] ey,
                                input logic [15:0] ecol, input logic efd);
        n_checks++;
        if (c_pix_valid !== 1'b1 || c_x !== ex || c_y !== ey || c_color !== ecol
            || c_frame_done !== efd || c_early !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got v=%b x=%0d y=%0d col=%h fd=%b early=%b, want v=1 x=%0d y=%0d col=%h fd=%b early=0",
                     name, c_pix_valid, c_x, c_y, c_color, c_frame_done, c_early, ex, ey, ecol, efd);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; oled_csn = 1'b1; oled_clk = 1'b0; oled_mosi = 1'b0;
        oled_dc = 1'b0; oled_resn = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_valid, cmd, pix_valid, pix_x, pix_y, pix_color, frame_done, err} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cv=%b cmd=%h pv=%b x=%0d y=%0d col=%h fd=%b err=%b, want all 0",
                     cmd_valid, cmd, pix_valid, pix_x, pix_y, pix_color, frame_done, err);
        end
        oled_csn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_pixels;
        send_byte(1'b0, 8'h2C);
        n_checks++;
        if (c_cmd_valid !== 1'b1 || c_cmd !== 8'h2C || c_early !== 1'b0) begin
            n_fail++;
            $display("FAIL ramwr_cmd: got cv=%b cmd=%h early=%b, want cv=1 cmd=2c early=0", c_cmd_valid, c_cmd, c_early);
        end
        send_pixel(16'hF800);
        expect_pixel("pix0", 8'd0, 7'd0, 16'hF800, 1'b0);
        send_pixel(16'h07E0);
        expect_pixel("pix1", 8'd1, 7'd0, 16'h07E0, 1'b0);
    endtask

    task automatic test_window;
        logic [7:0]  ex [7] = '{8'd10, 8'd11, 8'd12, 8'd10, 8'd11, 8'd12, 8'd10};
        logic [6:0]  ey [7] = '{7'd5, 7'd5, 7'd5, 7'd6, 7'd6, 7'd6, 7'd5};
        logic [15:0] col;
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0C);
        n_checks++;
        if (c_err !== 1'b0) begin
            n_fail++;
            $display("FAIL caset_ok_err: got err=%b, want 0", c_err);
        end
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
        send_byte(1'b0, 8'h2C);
        for (int p = 0; p < 7; p++) begin
            col = 16'h1111 * 16'(p + 1);
            send_pixel(col);
            expect_pixel($sformatf("win_pix%0d", p), ex[p], ey[p], col, (p == 5) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic test_bad_caset;
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h14);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0A);
        n_checks++;
        if (c_err !== 1'b1 || c_early !== 1'b0) begin
            n_fail++;
            $display("FAIL caset_reject_err: got err=%b early=%b, want err=1 early=0", c_err, c_early);
        end
        send_byte(1'b0, 8'h2C);
        send_pixel(16'hABCD);
        expect_pixel("after_reject", 8'd10, 7'd5, 16'hABCD, 1'b0);
    endtask

    task automatic test_nop_and_abort;
        send_pixel(16'h1234);
        expect_pixel("pre_nop", 8'd11, 7'd5, 16'h1234, 1'b0);
        send_byte(1'b0, 8'h00);
        n_checks++;
        if (c_cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_cmd_valid: got %b, want 0", c_cmd_valid);
        end
        send_pixel(16'h5678);
        expect_pixel("post_nop", 8'd12, 7'd5, 16'h5678, 1'b0);
        send_byte(1'b1, 8'h9A);
        send_byte(1'b0, 8'h36);
        n_checks++;
        if (c_cmd_valid !== 1'b1 || c_cmd !== 8'h36 || c_pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL madctl_abort: got cv=%b cmd=%h pv=%b, want cv=1 cmd=36 pv=0", c_cmd_valid, c_cmd, c_pix_valid);
        end
        send_byte(1'b1, 8'hBC);
        n_checks++;
        if (c_pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL half_pixel: got pv=%b, want 0", c_pix_valid);
        end
    endtask

    task automatic test_fragment;
        logic [4:0] bits = 5'b10110;
        logic       seen_early = 1'b0;
        logic       err_at4 = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk);
            oled_clk = 1'b0; oled_mosi = bits[i]; oled_dc = 1'b0;
            repeat (3) @(negedge clk);
            oled_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        @(negedge clk);
        oled_clk = 1'b0;
        repeat (2) @(negedge clk);
        oled_csn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4 && err) seen_early = 1'b1;
            if (k == 4) err_at4 = err;
        end
        n_checks++;
        if (err_at4 !== 1'b1 || seen_early !== 1'b0) begin
            n_fail++;
            $display("FAIL frag_err: got err=%b early=%b, want err=1 early=0", err_at4, seen_early);
        end
        repeat (3) @(negedge clk);
        oled_csn = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(1'b0, 8'h2A);
        n_checks++;
        if (c_cmd_valid !== 1'b1 || c_cmd !== 8'h2A || c_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_frag_cmd: got cv=%b cmd=%h err=%b, want cv=1 cmd=2a err=0", c_cmd_valid, c_cmd, c_err);
        end
    endtask

    task automatic test_resn;
        send_byte(1'b0, 8'h2C);
        send_pixel(16'h4321);
        expect_pixel("pre_resn", 8'd10, 7'd5, 16'h4321, 1'b0);
        @(negedge clk);
        oled_resn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_valid, cmd, pix_valid, pix_x, pix_y, pix_color, frame_done, err} !== 42'd0) begin
            n_fail++;
            $display("FAIL resn_outputs: got cmd=%h x=%0d y=%0d col=%h, want all 0", cmd, pix_x, pix_y, pix_color);
        end
        oled_resn = 1'b1;
        repeat (4) @(negedge clk);
        send_pixel(16'h1111);
        n_checks++;
        if (c_pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resn_fsm_cmd: got pv=%b, want 0", c_pix_valid);
        end
        send_byte(1'b0, 8'h2C);
        send_pixel(16'h2222);
        expect_pixel("resn_default_win", 8'd0, 7'd0, 16'h2222, 1'b0);
    endtask

    initial begin
        test_reset;
        test_basic_pixels;
        test_window;
        test_bad_caset;
        test_nop_and_abort;
        test_fragment;
        test_resn;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- Display-side receiver for the 4-wire ST7735-style SPI stream (csn, clk, mosi, dc, resn) produced by the team's OLED drivers.
- Oversamples the SPI lines in the system clock domain, assembles bytes and decodes CASET/RASET/RAMWR/SWRESET.
- Emits one pixel-write strobe with x, y and 16-bit colour per received RGB565 pixel.
- Used as a display model in simulation and for an on-FPGA mirror/capture path.

Parameters:
- C_x_size, 160, horizontal pixels; C_x_bits = $clog2(C_x_size) (localparam)
- C_y_size, 80, vertical pixels; C_y_bits = $clog2(C_y_size) (localparam)
- C_color_bits, 16, pixel width; fixed RGB565, any other value is unsupported

Ports:
- clk  in  1  system clock; must be at least 4x the oled_clk frequency
- rst  in  1  synchronous, active-high reset
- oled_csn  in  1  SPI chip select, active low
- oled_clk  in  1  SPI clock, mode 0 (sample on rising edge)
- oled_mosi  in  1  SPI data, MSB first
- oled_dc  in  1  0 = command byte, 1 = argument/pixel byte
- oled_resn  in  1  display reset, active low
- cmd_valid  out  1  one-cycle pulse: command byte decoded
- cmd  out  8  last command byte; valid while cmd_valid is high
- pix_valid  out  1  one-cycle pulse: pixel written
- pix_x  out  C_x_bits  pixel column
- pix_y  out  C_y_bits  pixel row
- pix_color  out  C_color_bits  {high byte, low byte}
- frame_done  out  1  pulse together with pix_valid when the pixel at (xe,ye) is written
- err  out  1  one-cycle pulse: protocol error

Behaviour:
- Reset values:
  - All outputs 0.
  - Window xs=0, xe=C_x_size-1, ys=0, ye=C_y_size-1.
  - Cursor at (xs,ys); FSM in CMD; bit counter 0.
- Input path:
  - oled_* pass through 2-flop synchronizers.
  - Rising edge of oled_clk is detected from the synchronized samples.
  - Sampling mosi and dc happens only when synced csn=0.
- Byte assembly:
  - Shift left, MSB first; byte complete on the 8th sampled edge.
  - The byte is tagged with dc as sampled on its 8th edge.
  - csn going high clears the bit counter. If csn rises with 1..7 bits pending, err pulses and the partial byte is dropped.
  - Framing persists across csn toggles at byte boundaries.
- Latency: cmd_valid, pix_valid and err assert exactly 4 clk cycles after the completing oled_clk rising edge reaches the pin (2 sync + 1 edge detect + 1 output register).
- oled_resn synced low: behaves exactly like rst for decoder state and window. Outputs are forced 0 while it is held low.
- FSM states: CMD, CASET_ARG, RASET_ARG, RAMWR_HI, RAMWR_LO.
  - Any dc=0 byte exits the current state. A partial argument set or a pending high pixel byte is discarded silently.
  - 0x00 (NOP): ignored entirely. No cmd_valid, no state change, RAMWR continues.
  - Every other dc=0 byte: cmd_valid=1, cmd=byte.
  - 0x2A: go to CASET_ARG, collect 4 bytes {xs_hi, xs_lo, xe_hi, xe_lo}.
  - 0x2B: go to RASET_ARG, collect 4 bytes {ys_hi, ys_lo, ye_hi, ye_lo}.
  - 0x2C: go to RAMWR_HI. Cursor is reloaded to (xs,ys).
  - 0x01 (SWRESET): window restored to defaults; go to CMD.
  - Other opcodes: go to CMD; their dc=1 argument bytes are ignored.
- CASET/RASET commit:
  - Applied on the 4th argument byte as one 16-bit start and one 16-bit end value.
  - Rejected if start > end or end >= size: window kept and err pulses.
  - Either way the FSM returns to CMD.
- Pixel stream:
  - RAMWR_HI latches the high byte.
  - RAMWR_LO emits pix_valid with the current cursor, then advances it.
  - Advance: x+1 if x < xe, else x=xs and y+1 if y < ye, else y=ys. frame_done pulses on the pixel written at (xe,ye).
  - The stream continues indefinitely until a dc=1 byte run is ended by a dc=0 byte.
- Simultaneous events: rst/resn dominate any byte completion in the same cycle.

Decomposition:
- Package oled_pkg:
  - Opcode constants: CMD_NOP=0x00, CMD_SWRESET=0x01, CMD_CASET=0x2A, CMD_RASET=0x2B, CMD_RAMWR=0x2C.
  - Default sizes 160/80; colour width 16.
- Sub-module spi_byte_rx:
  - Contains the synchronizers, edge detect and shift register.
  - Outputs byte_valid, byte[7:0], byte_dc and frag_err.
- The top level holds the decode FSM, window registers and cursor.

Test Plan:
- rst, then send 0x2C and pixels 0xF800, 0x07E0 (SPI at clk/8) -> pix_valid at (0,0) color 0xF800, then (1,0) color 0x07E0; each 4 clk after the last edge.
- CASET 0,10,0,12 and RASET 0,5,0,6, then RAMWR with 6 pixels -> coords (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); frame_done only on the 6th; a 7th pixel lands at (10,5).
- CASET 0,20,0,10 (start>end) -> err pulse, window unchanged; next RAMWR starts at the previous xs.
- RAMWR stream interleaved with dc=0 byte 0x00 between pixels -> no cmd_valid and pixel coordinates continue uninterrupted; a dc=0 0x36 mid-pixel (after the high byte only) -> cmd_valid with cmd=0x36, no pix_valid for the half pixel.
- 5 bits shifted then csn high -> err pulse; the next full byte 0x2A decodes correctly with cmd_valid and cmd=0x2A.
- oled_resn low for 3 clk during a RAMWR stream -> outputs held 0, window back to defaults, FSM in CMD; subsequent dc=1 bytes produce no pix_valid.
